// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: receive side of the 640x480@60 VGA timing path.
// Registers an incoming sync/valid/RGB stream, verifies line and frame
// periods against the nominal totals, and once locked emits one write
// strobe per active pixel with its recovered coordinates and 12-bit colour.
module vga_rx_decoder #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_data,
    output logic        pix_we,
    output logic        frame_start,
    output logic        locked,
    output logic        err_timing,
    output logic [9:0]  h_meas
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [9:0]  H_ACTIVE_C = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
    localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

    // Stage-1 input registers; only the colour nibbles that reach pix_data are kept
    logic        hs_s1_q, vs_s1_q, valid_s1_q;
    logic        hs_prev_q, vs_prev_q;
    logic [11:0] rgb_s1_q;

    // Timing counters and FSM state
    logic [10:0] lcnt_q, lcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [9:0]  xcnt_q, xcnt_d;
    logic [9:0]  ycnt_q, ycnt_d;
    logic        line_had_valid_q, line_had_valid_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  good_q, good_d;

    // Output registers
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [11:0] pix_data_q, pix_data_d;
    logic        pix_we_q, pix_we_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        err_timing_q, err_timing_d;
    logic [9:0]  h_meas_q, h_meas_d;

    logic hfall, vfall;
    logic h_bad, v_bad, x_bad, y_bad, fault;
    logic in_locked;

    assign hfall = hs_prev_q & ~hs_s1_q;
    assign vfall = vs_prev_q & ~vs_s1_q;

    assign h_bad = hfall & (lcnt_q != H_TOTAL_C);
    assign v_bad = vfall & (vcnt_q != V_TOTAL_C);
    assign x_bad = valid_s1_q & (xcnt_q == H_ACTIVE_C);
    assign y_bad = valid_s1_q & (ycnt_q == V_ACTIVE_C);
    assign fault = h_bad | v_bad | x_bad | y_bad;

    assign in_locked = (state_q == ST_LOCKED);

    // Stage 1: capture pins, keep previous sync levels for edge detection
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hs_s1_q    <= 1'b1;
            vs_s1_q    <= 1'b1;
            hs_prev_q  <= 1'b1;
            vs_prev_q  <= 1'b1;
            valid_s1_q <= 1'b0;
            rgb_s1_q   <= '0;
        end else begin
            hs_s1_q    <= hsync;
            vs_s1_q    <= vsync;
            hs_prev_q  <= hs_s1_q;
            vs_prev_q  <= vs_s1_q;
            valid_s1_q <= valid;
            rgb_s1_q   <= {vga_r[7:4], vga_g[7:4], vga_b[7:4]};
        end
    end

    // Line/frame period counters and pixel coordinate counters
    always_comb begin
        lcnt_d           = lcnt_q;
        vcnt_d           = vcnt_q;
        xcnt_d           = xcnt_q;
        ycnt_d           = ycnt_q;
        line_had_valid_d = line_had_valid_q;

        if (hfall) begin
            lcnt_d = 11'd1;
        end else if (lcnt_q != '1) begin
            lcnt_d = lcnt_q + 11'd1;
        end

        // Coincident hfall/vfall is a frame end: vfall reload wins
        if (vfall) begin
            vcnt_d = 10'd1;
        end else if (hfall && vcnt_q != '1) begin
            vcnt_d = vcnt_q + 10'd1;
        end

        if (hfall) begin
            xcnt_d = '0;
        end else if (valid_s1_q && xcnt_q != '1) begin
            xcnt_d = xcnt_q + 10'd1;
        end

        if (vfall) begin
            ycnt_d = '0;
        end else if (hfall && line_had_valid_q && ycnt_q != '1) begin
            ycnt_d = ycnt_q + 10'd1;
        end

        if (hfall) begin
            line_had_valid_d = 1'b0;
        end else if (valid_s1_q) begin
            line_had_valid_d = 1'b1;
        end
    end

    // Lock FSM: SEARCH waits for a frame edge, VERIFY counts good frames, LOCKED watches for faults
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                if (vfall) begin
                    state_d = ST_VERIFY;
                    good_d  = '0;
                end
            end
            ST_VERIFY: begin
                if (h_bad) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end else if (vfall) begin
                    if (vcnt_q == V_TOTAL_C) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_C) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (fault) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
            end
        endcase
    end

    // Output stage: strobe and coordinates of the pixel held in stage 1
    always_comb begin
        pix_we_d      = valid_s1_q & in_locked & ~fault;
        err_timing_d  = in_locked & fault;
        frame_start_d = vfall;
        locked_d      = in_locked;
        h_meas_d      = h_meas_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_data_d    = pix_data_q;

        if (hfall) begin
            h_meas_d = (lcnt_q > 11'd1023) ? '1 : lcnt_q[9:0];
        end
        // Coordinates/colour hold the last strobed pixel between strobes
        if (pix_we_d) begin
            pix_x_d    = xcnt_q;
            pix_y_d    = ycnt_q;
            pix_data_d = rgb_s1_q;
        end
    end

    // State, counter and output registers
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            lcnt_q           <= '0;
            vcnt_q           <= '0;
            xcnt_q           <= '0;
            ycnt_q           <= '0;
            line_had_valid_q <= 1'b0;
            state_q          <= ST_SEARCH;
            good_q           <= '0;
            pix_x_q          <= '0;
            pix_y_q          <= '0;
            pix_data_q       <= '0;
            pix_we_q         <= 1'b0;
            frame_start_q    <= 1'b0;
            locked_q         <= 1'b0;
            err_timing_q     <= 1'b0;
            h_meas_q         <= '0;
        end else begin
            lcnt_q           <= lcnt_d;
            vcnt_q           <= vcnt_d;
            xcnt_q           <= xcnt_d;
            ycnt_q           <= ycnt_d;
            line_had_valid_q <= line_had_valid_d;
            state_q          <= state_d;
            good_q           <= good_d;
            pix_x_q          <= pix_x_d;
            pix_y_q          <= pix_y_d;
            pix_data_q       <= pix_data_d;
            pix_we_q         <= pix_we_d;
            frame_start_q    <= frame_start_d;
            locked_q         <= locked_d;
            err_timing_q     <= err_timing_d;
            h_meas_q         <= h_meas_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign pix_we      = pix_we_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err_timing  = err_timing_q;
    assign h_meas      = h_meas_q;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb_vga_rx_decoder: drives a scaled-down VGA stream (20 clocks/line,
// 12 lines/frame, 8x6 active) and scoreboards the pixel strobes.
module tb_vga_rx_decoder;

    localparam int unsigned HT = 20;
    localparam int unsigned VT = 12;
    localparam int unsigned HA = 8;
    localparam int unsigned VA = 6;
    localparam int unsigned LF = 2;
    localparam int HS_W     = 2;
    localparam int VS_LINES = 2;
    localparam int ACT_X0   = 4;
    localparam int ACT_Y0   = 3;

    logic        pclk = 1'b0;
    logic        reset;
    logic        hsync, vsync, valid;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [9:0]  pix_x, pix_y, h_meas;
    logic [11:0] pix_data;
    logic        pix_we, frame_start, locked, err_timing;

    vga_rx_decoder #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .LOCK_FRAMES (LF)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .valid       (valid),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .pix_we      (pix_we),
        .frame_start (frame_start),
        .locked      (locked),
        .err_timing  (err_timing),
        .h_meas      (h_meas)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_mis = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int fs_cnt = 0;
    logic [31:0] exp_q[$];
    int  prev_len = 0;
    bit  prev_known = 0;
    bit  special = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expected pixel per strobe, counts one-cycle pulses
    always @(negedge pclk) begin
        logic [31:0] e;
        if (pix_we === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_strobe: actual x=%0d y=%0d data=0x%0h required no strobe (t=%0t)",
                         pix_x, pix_y, pix_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("pixel{x,y,data}", {pix_x, pix_y, pix_data}, e);
            end
        end
        if (err_timing === 1'b1) err_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
    end

    task automatic drive(input logic hs, input logic vs, input logic v,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        hsync = hs;
        vsync = vs;
        valid = v;
        vga_r = r;
        vga_g = g;
        vga_b = b;
        @(posedge pclk);
        #1;
    endtask

    // One frame of stimulus; a pixel is expected while the decoder should be
    // locked and until the first out-of-window pixel of that frame.
    task automatic frame(input int lines, input int act_lines, input bit exp_lock,
                         input bit exp_lock_end, input int short_line,
                         input int extra_line, input int exp_err);
        int fs0, err0, len, nvalid, px, py;
        bit strobing, act;
        logic hs, vs, v;
        logic [7:0] r, g, b;
        logic [11:0] d;
        fs0 = fs_cnt;
        err0 = err_cnt;
        strobing = exp_lock;
        for (int ln = 0; ln < lines; ln++) begin
            len    = (ln == short_line) ? int'(HT) - 1 : int'(HT);
            nvalid = (ln == extra_line) ? int'(HA) + 1 : int'(HA);
            act    = (ln >= ACT_Y0) && (ln < ACT_Y0 + act_lines);
            for (int x = 0; x < len; x++) begin
                hs = (x >= HS_W);
                vs = (ln >= VS_LINES);
                v  = act && (x >= ACT_X0) && (x < ACT_X0 + nvalid);
                r = '0; g = '0; b = '0;
                if (ln == 2 && x == 0) check("locked_mid_frame", locked, exp_lock);
                if (x == 5 && prev_known) check("h_meas", h_meas, prev_len);
                if (v) begin
                    px = x - ACT_X0;
                    py = ln - ACT_Y0;
                    if (special && px == 0 && py == 0) begin
                        r = 8'hA5; g = 8'h3C; b = 8'hF0;
                        d = 12'hA3F;
                        special = 0;
                    end else begin
                        r = 8'(px * 16 + py);
                        g = 8'(8'hC3 ^ 8'(px * 16));
                        b = 8'(py * 32 + 7);
                        d = {r[7:4], g[7:4], b[7:4]};
                    end
                    if (strobing) begin
                        if (px >= int'(HA) || py >= int'(VA)) strobing = 0;
                        else exp_q.push_back({10'(px), 10'(py), d});
                    end
                end
                drive(hs, vs, v, r, g, b);
            end
            prev_len = len;
            prev_known = 1;
        end
        check("frame_start_pulses", fs_cnt - fs0, 1);
        check("err_timing_pulses", err_cnt - err0, exp_err);
        check("locked_end_frame", locked, exp_lock_end);
        check("strobes_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int s0;
        reset = 1'b1;
        hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
        vga_r = '0; vga_g = '0; vga_b = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_pix_we", pix_we, 0);
        check("rst_locked", locked, 0);
        check("rst_err_timing", err_timing, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_h_meas", h_meas, 0);
        check("rst_pix_xydata", {pix_x, pix_y, pix_data}, 0);
        reset = 1'b0;

        // Lock from reset: locked after third vfall
        frame(VT, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 0, 0, -1, -1, 0);
        special = 1;
        s0 = strobe_cnt;
        frame(VT, VA, 1, 1, -1, -1, 0);
        check("strobes_per_frame", strobe_cnt - s0, 48);

        // Short line (19 clocks) while locked, relock three frames later
        frame(VT, VA, 1, 0, 10, -1, 1);
        frame(VT, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 1, 1, -1, -1, 0);

        // Nine valid pixels on one line while locked
        frame(VT, VA, 1, 0, -1, 5, 1);
        // Frame of 11 lines while in VERIFY: no error pulse, back to SEARCH
        frame(VT - 1, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 1, 1, -1, -1, 0);

        // Reset mid-frame while locked
        frame(5, VA, 1, 1, -1, -1, 0);
        hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_pix_we", pix_we, 0);
        check("midrst_locked", locked, 0);
        check("midrst_err_timing", err_timing, 0);
        check("midrst_frame_start", frame_start, 0);
        check("midrst_h_meas", h_meas, 0);
        check("midrst_pix_xydata", {pix_x, pix_y, pix_data}, 0);
        repeat (3) @(posedge pclk);
        #1;
        reset = 1'b0;
        prev_known = 0;
        frame(VT, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 0, 0, -1, -1, 0);
        frame(VT, VA, 1, 1, -1, -1, 0);

        // Seventh active line while locked: its first pixel faults
        frame(VT, VA + 1, 1, 0, -1, -1, 1);

        repeat (4) @(posedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
